// File: rtl/irda_wb_sequencer.sv
// irda_wb_sequencer: command-FIFO driven Wishbone master that replays write/read/compare/poll scripts
module irda_wb_sequencer #(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter int DEPTH    = 16,
    parameter int TMO      = 1024,
    parameter int POLL_MAX = 256
) (
    input  logic          clk,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TMO + 1);
    localparam int NW = $clog2(POLL_MAX + 1);
    localparam int EW = AW + DW + 2;

    typedef enum logic [2:0] {IDLE, FETCH, BUS, CHECK, ERR} state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          rdy_q, we_q, rd_valid_q, done_q, error_q, error_d;
    logic [1:0]    op_q, err_code_q, err_code_d;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q, rd_data_q;
    logic [TW-1:0] tmo_q;
    logic [NW-1:0] poll_q;
    logic          empty, push, pop, flush, ack, tmo_hit, match;

    assign empty     = cnt_q == '0;
    assign cmd_ready = rdy_q && cnt_q != CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready && state_q != ERR;
    assign pop       = state_q == FETCH && !empty;
    assign flush     = state_q == ERR;
    assign ack       = state_q == BUS && wb_ack_i;
    assign tmo_hit   = state_q == BUS && !wb_ack_i && tmo_q == TW'(TMO - 1);
    assign match     = rd_data_q == dat_q;
    assign head      = mem_q[rp_q];

    assign busy      = state_q != IDLE;
    assign wb_cyc_o  = state_q == BUS;
    assign wb_stb_o  = state_q == BUS;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

    // Sequencer next-state and sticky error status
    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = FETCH;
                error_d    = 1'b0;
                err_code_d = 2'b00;
            end
            FETCH: state_d = empty ? IDLE : BUS;
            BUS: if (ack) state_d = CHECK;
                 else if (tmo_hit) begin
                     state_d    = ERR;
                     error_d    = 1'b1;
                     err_code_d = 2'b01;
                 end
            CHECK: if (op_q == 2'b00 || op_q == 2'b01 || match) state_d = FETCH;
                   else if (op_q == 2'b10 || poll_q == NW'(POLL_MAX - 1)) begin
                       state_d    = ERR;
                       error_d    = 1'b1;
                       err_code_d = op_q;
                   end else state_d = BUS;
            default: state_d = IDLE;
        endcase
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // Bus command latch, timeout/poll counters and read result capture
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            op_q       <= 2'b00;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= '0;
            poll_q     <= '0;
        end else begin
            if (pop) begin
                op_q  <= head[EW-1 -: 2];
                we_q  <= head[EW-1 -: 2] == 2'b00;
                adr_q <= head[DW +: AW];
                dat_q <= head[DW-1:0];
            end
            if (ack && op_q != 2'b00) rd_data_q <= wb_dat_i;
            rd_valid_q <= ack && op_q != 2'b00;
            done_q     <= state_q == FETCH && empty;
            tmo_q      <= state_q == BUS ? tmo_q + TW'(1) : '0;
            poll_q     <= state_q == FETCH ? '0 : (state_q == CHECK && state_d == BUS) ? poll_q + NW'(1) : poll_q;
        end
    end

    // FIFO pointers and occupancy; an error flush overrides any push
    always_ff @(posedge clk) begin
        if (wb_rst_i || flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            rdy_q <= !wb_rst_i;
        end else begin
            wp_q  <= wp_q + PW'(push);
            rp_q  <= rp_q + PW'(pop);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            rdy_q <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {cmd_op, cmd_addr, cmd_data};
    end
endmodule

// File: tb/tb_irda_wb_sequencer.sv
// tb_irda_wb_sequencer: scoreboard bench with a scripted Wishbone slave
module tb_irda_wb_sequencer;
    localparam int DW = 32, AW = 4, DEPTH = 8, TMO = 16, PM = 4;

    typedef struct packed {logic we; logic [AW-1:0] adr; logic [DW-1:0] dat;} bus_t;

    logic          clk = 0;
    logic          wb_rst_i = 1, cmd_valid = 0, start = 0;
    logic [1:0]    cmd_op = 0;
    logic [AW-1:0] cmd_addr = 0;
    logic [DW-1:0] cmd_data = 0;
    logic          cmd_ready, busy, done, error, rd_valid, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [1:0]    err_code;
    logic [DW-1:0] rd_data, wb_dat_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_i = 0;
    logic          wb_ack_i = 0;

    bus_t          exp_bus[$];
    logic [DW-1:0] exp_rd[$];
    logic [2:0]    exp_evt[$];
    logic [DW-1:0] rsp_q[$];
    logic          ack_en = 1;
    logic [DW-1:0] slave_def = 32'h55;
    int            checks = 0, errors = 0, stb_run = 0, last_stb = 0;
    logic          err_prev = 0;

    irda_wb_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TMO(TMO), .POLL_MAX(PM)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .rd_data(rd_data), .rd_valid(rd_valid),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: acks one cycle after stb rises, returning queued read data
    always @(posedge clk) begin
        #1;
        if (ack_en && wb_stb_o && !wb_ack_i) begin
            wb_ack_i = 1;
            wb_dat_i = wb_we_o ? '0 : (rsp_q.size() != 0 ? rsp_q.pop_front() : slave_def);
        end else wb_ack_i = 0;
    end

    // Monitor: pops expectations whenever the DUT presents a transfer, read result or end event
    always @(negedge clk) begin
        if (wb_stb_o) stb_run++;
        else begin
            if (stb_run != 0) last_stb = stb_run;
            stb_run = 0;
        end
        if (wb_stb_o && wb_ack_i) begin
            if (exp_bus.size() == 0) check("unexpected_bus", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("bus", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'(exp_bus.pop_front()));
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) check("unexpected_rd", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
        if (done || (error && !err_prev)) begin
            if (exp_evt.size() == 0) check("unexpected_evt", 64'({error, err_code}), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("end_evt", 64'({error, err_code}), 64'(exp_evt.pop_front()));
        end
        err_prev = error;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int n = 0; n < 100 && !cmd_ready; n++) cyc();
        check("push_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1;
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        cyc();
        cmd_valid = 0;
    endtask

    task automatic run();
        start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 3000 && busy; n++) cyc();
        check("run_finished", 64'(busy), 64'd0);
        repeat (3) cyc();
        check("drained", 64'(exp_bus.size() + exp_rd.size() + exp_evt.size()), 64'd0);
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 64'd0);
        check("rst_status", 64'({busy, done, error, rd_valid, err_code, cmd_ready}), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        wb_rst_i = 0;
        check("ready_low_at_release", 64'(cmd_ready), 64'd0);
        cyc();
        check("ready_after_release", 64'(cmd_ready), 64'd1);

        // Script: two writes then a read
        push(2'b00, 4'h0, 32'h1B);
        push(2'b00, 4'h8, 32'd200000);
        push(2'b01, 4'h0, 32'h0);
        rsp_q.push_back(32'hCAFE_0001);
        exp_bus.push_back({1'b1, 4'h0, 32'h1B});
        exp_bus.push_back({1'b1, 4'h8, 32'd200000});
        exp_bus.push_back({1'b0, 4'h0, 32'h0});
        exp_rd.push_back(32'hCAFE_0001);
        exp_evt.push_back(3'b000);
        run();
        check("script_error", 64'(error), 64'd0);

        // Compare mismatch flushes the queued write
        push(2'b10, 4'h4, 32'hA5);
        push(2'b00, 4'h1, 32'h77);
        rsp_q.push_back(32'h5A);
        exp_bus.push_back({1'b0, 4'h4, 32'hA5});
        exp_rd.push_back(32'h5A);
        exp_evt.push_back(3'b110);
        run();
        check("cmp_err", 64'({error, err_code}), 64'b110);
        exp_evt.push_back(3'b000);
        run();
        check("err_cleared", 64'({error, err_code}), 64'd0);

        // Poll succeeds on the fourth read
        push(2'b11, 4'h2, 32'h0);
        foreach (rsp_q[i]) rsp_q.delete(i);
        rsp_q.push_back(32'h3);
        rsp_q.push_back(32'h7);
        rsp_q.push_back(32'h1);
        rsp_q.push_back(32'h0);
        repeat (4) exp_bus.push_back({1'b0, 4'h2, 32'h0});
        exp_rd.push_back(32'h3);
        exp_rd.push_back(32'h7);
        exp_rd.push_back(32'h1);
        exp_rd.push_back(32'h0);
        exp_evt.push_back(3'b000);
        run();

        // Poll never matches: POLL_MAX attempts then error 11
        push(2'b11, 4'h2, 32'h0);
        repeat (PM) exp_bus.push_back({1'b0, 4'h2, 32'h0});
        repeat (PM) exp_rd.push_back(32'h55);
        exp_evt.push_back(3'b111);
        run();
        check("poll_err", 64'({error, err_code}), 64'b111);

        // Timeout: stb high exactly TMO cycles
        ack_en = 0;
        push(2'b00, 4'h5, 32'h12);
        exp_evt.push_back(3'b101);
        run();
        check("tmo_stb_len", 64'(last_stb), 64'(TMO));
        check("tmo_status", 64'({wb_cyc_o, error, err_code}), 64'b0101);
        ack_en = 1;

        // FIFO full: DEPTH accepted, extra rejected, replay in order
        for (int i = 0; i < DEPTH; i++) begin
            push(2'b00, 4'(i), 32'(100 + i));
            exp_bus.push_back({1'b1, 4'(i), 32'(100 + i)});
        end
        check("full_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1;
        cmd_op = 2'b00;
        cmd_addr = 4'hF;
        cmd_data = 32'hDEAD;
        cyc();
        cmd_valid = 0;
        exp_evt.push_back(3'b000);
        run();

        // Reset mid-transaction
        ack_en = 0;
        push(2'b00, 4'h3, 32'h9);
        start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 20 && !wb_stb_o; n++) cyc();
        check("stb_before_rst", 64'(wb_stb_o), 64'd1);
        wb_rst_i = 1;
        cyc();
        check("rst_mid_bus", 64'({wb_cyc_o, wb_stb_o, busy, cmd_ready}), 64'd0);
        wb_rst_i = 0;
        cyc();
        check("ready_after_mid_rst", 64'(cmd_ready), 64'd1);
        ack_en = 1;
        exp_evt.push_back(3'b000);
        start = 1;
        cyc();
        start = 0;
        check("empty_run_cycle1", 64'({busy, done}), 64'b10);
        cyc();
        check("empty_run_cycle2", 64'({busy, done}), 64'b01);
        repeat (3) cyc();
        check("drained_final", 64'(exp_bus.size() + exp_rd.size() + exp_evt.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
